// File: rtl/vga_timing_gen_pkg.sv
// Shared definitions for the VGA timing generator: default 640x480@60 geometry,
// per-axis phase encoding and sync polarity constants.
package vga_timing_gen_pkg;

  localparam int unsigned CountW = 10;

  localparam int unsigned DefHActive = 640;
  localparam int unsigned DefHFp     = 16;
  localparam int unsigned DefHSync   = 96;
  localparam int unsigned DefHBp     = 48;
  localparam int unsigned DefVActive = 480;
  localparam int unsigned DefVFp     = 10;
  localparam int unsigned DefVSync   = 2;
  localparam int unsigned DefVBp     = 33;
  localparam int unsigned DefDataW   = 24;

  localparam bit SyncActiveLow  = 1'b0;
  localparam bit SyncActiveHigh = 1'b1;

  typedef enum logic [1:0] {
    PhActive = 2'd0,
    PhFp     = 2'd1,
    PhSync   = 2'd2,
    PhBp     = 2'd3
  } phase_e;

  function automatic phase_e next_phase(input phase_e ph);
    phase_e nxt;
    case (ph)
      PhActive: nxt = PhFp;
      PhFp:     nxt = PhSync;
      PhSync:   nxt = PhBp;
      default:  nxt = PhActive;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel stream handshake between the upstream pipeline (master) and the
// timing generator (slave); the slave pulls one pixel per active position.
interface vga_timing_gen_if
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW
) ();

  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              pix_ready;

  modport master (
    output pix_data,
    output pix_valid,
    input  pix_ready
  );

  modport slave (
    input  pix_data,
    input  pix_valid,
    output pix_ready
  );

endinterface

// File: rtl/vga_timing_gen_sync_axis_fsm.sv
// One display axis: ACTIVE/FP/SYNC/BP phase FSM with a per-phase counter.
// wrap_o fires on the step that leaves the last back-porch count.
module vga_timing_gen_sync_axis_fsm
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned ActiveLen = DefHActive,
  parameter int unsigned FpLen     = DefHFp,
  parameter int unsigned SyncLen   = DefHSync,
  parameter int unsigned BpLen     = DefHBp
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              step_i,
  output logic              wrap_o,
  output phase_e            state_o,
  output logic [CountW-1:0] count_o
);

  localparam logic [CountW-1:0] ActiveLast = CountW'(ActiveLen - 1);
  localparam logic [CountW-1:0] FpLast     = CountW'(FpLen - 1);
  localparam logic [CountW-1:0] SyncLast   = CountW'(SyncLen - 1);
  localparam logic [CountW-1:0] BpLast     = CountW'(BpLen - 1);

  phase_e            state_q, state_d;
  logic [CountW-1:0] count_q, count_d;
  logic [CountW-1:0] last_count;
  logic              at_last;

  always_comb begin
    last_count = BpLast;
    unique case (state_q)
      PhActive: last_count = ActiveLast;
      PhFp:     last_count = FpLast;
      PhSync:   last_count = SyncLast;
      PhBp:     last_count = BpLast;
      default:  last_count = BpLast;
    endcase
  end

  assign at_last = (count_q == last_count);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wrap_o  = 1'b0;
    if (step_i) begin
      if (at_last) begin
        state_d = next_phase(state_q);
        count_d = '0;
        wrap_o  = (state_q == PhBp);
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= PhActive;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign state_o = state_q;
  assign count_o = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA display timing and pixel output stage: H/V phase FSMs advanced by pix_en,
// pixel pull on active positions, registered sync/blank/position outputs.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DefHActive,
  parameter int unsigned H_FP     = DefHFp,
  parameter int unsigned H_SYNC   = DefHSync,
  parameter int unsigned H_BP     = DefHBp,
  parameter int unsigned V_ACTIVE = DefVActive,
  parameter int unsigned V_FP     = DefVFp,
  parameter int unsigned V_SYNC   = DefVSync,
  parameter int unsigned V_BP     = DefVBp,
  parameter bit          SYNC_POL = SyncActiveLow,
  parameter int unsigned DATA_W   = DefDataW
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                pix_en,
  vga_timing_gen_if.slave     pix_if,
  input  logic                clr_underflow,
  output logic                hsync,
  output logic                vsync,
  output logic                active,
  output logic [DATA_W-1:0]   rgb,
  output logic [CountW-1:0]   x,
  output logic [CountW-1:0]   y,
  output logic                frame_start,
  output logic                underflow
);

  phase_e            h_state, v_state;
  logic [CountW-1:0] h_count, v_count;
  logic              h_wrap;
  logic              v_wrap_unused;
  logic              in_active;
  logic              pix_ready;

  vga_timing_gen_sync_axis_fsm #(
    .ActiveLen (H_ACTIVE),
    .FpLen     (H_FP),
    .SyncLen   (H_SYNC),
    .BpLen     (H_BP)
  ) u_h_axis (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .step_i  (pix_en),
    .wrap_o  (h_wrap),
    .state_o (h_state),
    .count_o (h_count)
  );

  // The vertical axis advances one line each time the horizontal axis wraps.
  vga_timing_gen_sync_axis_fsm #(
    .ActiveLen (V_ACTIVE),
    .FpLen     (V_FP),
    .SyncLen   (V_SYNC),
    .BpLen     (V_BP)
  ) u_v_axis (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .step_i  (h_wrap),
    .wrap_o  (v_wrap_unused),
    .state_o (v_state),
    .count_o (v_count)
  );

  assign in_active        = (h_state == PhActive) && (v_state == PhActive);
  assign pix_ready        = pix_en && in_active;
  assign pix_if.pix_ready = pix_ready;

  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  logic              active_q, active_d;
  logic [DATA_W-1:0] rgb_q, rgb_d;
  logic [CountW-1:0] x_q, x_d;
  logic [CountW-1:0] y_q, y_d;
  logic              frame_start_q, frame_start_d;
  logic              underflow_q, underflow_d;

  // Registered outputs describe the position consumed on this edge and hold
  // between enables; frame_start and underflow are evaluated every clock.
  always_comb begin
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    active_d      = active_q;
    rgb_d         = rgb_q;
    x_d           = x_q;
    y_d           = y_q;
    frame_start_d = 1'b0;
    underflow_d   = underflow_q;
    if (pix_en) begin
      hsync_d       = (h_state == PhSync) ? SYNC_POL : ~SYNC_POL;
      vsync_d       = (v_state == PhSync) ? SYNC_POL : ~SYNC_POL;
      active_d      = in_active;
      x_d           = in_active ? h_count : '0;
      y_d           = in_active ? v_count : '0;
      rgb_d         = (in_active && pix_if.pix_valid) ? pix_if.pix_data : '0;
      frame_start_d = in_active && (h_count == '0) && (v_count == '0);
    end
    if (pix_ready && !pix_if.pix_valid) begin
      underflow_d = 1'b1;
    end else if (clr_underflow) begin
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      active_q      <= 1'b0;
      rgb_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      rgb_q         <= rgb_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
      underflow_q   <= underflow_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign rgb         = rgb_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = frame_start_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: two small-geometry instances (both sync
// polarities) and one default-geometry instance share the same stimulus.
module tb_vga_timing_gen;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        act;
    logic        fs;
    logic        uf;
    logic [23:0] rgb;
    logic [9:0]  x;
    logic [9:0]  y;
  } obs_t;

  typedef obs_t [2:0] exp_t;

  // Instance 0/1: 8x4 active in a 15x8 raster; instance 2: 640x480 in 800x525.
  localparam int HA [3] = '{8, 8, 640};
  localparam int HF [3] = '{2, 2, 16};
  localparam int HS [3] = '{3, 3, 96};
  localparam int HB [3] = '{2, 2, 48};
  localparam int VA [3] = '{4, 4, 480};
  localparam int VF [3] = '{1, 1, 10};
  localparam int VS [3] = '{2, 2, 2};
  localparam int VB [3] = '{1, 1, 33};
  localparam bit POL [3] = '{1'b0, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic pix_en = 1'b0;
  logic clr_underflow = 1'b0;

  logic [2:0]  hs, vs, act, fs, uf, rdy;
  logic [23:0] rgb [3];
  logic [9:0]  xo [3];
  logic [9:0]  yo [3];

  vga_timing_gen_if #(.DATA_W(24)) if_s ();
  vga_timing_gen_if #(.DATA_W(24)) if_p ();
  vga_timing_gen_if #(.DATA_W(24)) if_d ();

  assign rdy = {if_d.pix_ready, if_p.pix_ready, if_s.pix_ready};

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b0), .DATA_W(24)
  ) dut_s (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en), .pix_if(if_s.slave),
    .clr_underflow(clr_underflow), .hsync(hs[0]), .vsync(vs[0]), .active(act[0]),
    .rgb(rgb[0]), .x(xo[0]), .y(yo[0]), .frame_start(fs[0]), .underflow(uf[0])
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b1), .DATA_W(24)
  ) dut_p (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en), .pix_if(if_p.slave),
    .clr_underflow(clr_underflow), .hsync(hs[1]), .vsync(vs[1]), .active(act[1]),
    .rgb(rgb[1]), .x(xo[1]), .y(yo[1]), .frame_start(fs[1]), .underflow(uf[1])
  );

  vga_timing_gen dut_d (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en), .pix_if(if_d.slave),
    .clr_underflow(clr_underflow), .hsync(hs[2]), .vsync(vs[2]), .active(act[2]),
    .rgb(rgb[2]), .x(xo[2]), .y(yo[2]), .frame_start(fs[2]), .underflow(uf[2])
  );

  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  exp_t sbq [$];
  int   mt [3];
  obs_t mo [3];

  task automatic chk(input string nm, input int g, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d @%0t: got %0h expected %0h", nm, g, $time, got, exp);
    end
  endtask

  // Position from the raw tick count, independent of any phase bookkeeping.
  function automatic obs_t predict(input int g, input obs_t prev, input int t, input bit en,
                                   input bit valid, input bit clr, input logic [23:0] d,
                                   output bit rdy_exp);
    obs_t o;
    int   lt, fl, hp, ln;
    bit   a;
    o = prev;
    o.fs = 1'b0;
    a = 1'b0;
    if (en) begin
      lt = HA[g] + HF[g] + HS[g] + HB[g];
      fl = VA[g] + VF[g] + VS[g] + VB[g];
      hp = t % lt;
      ln = (t / lt) % fl;
      a = (hp < HA[g]) && (ln < VA[g]);
      o.hs = (hp >= HA[g] + HF[g] && hp < HA[g] + HF[g] + HS[g]) ? POL[g] : !POL[g];
      o.vs = (ln >= VA[g] + VF[g] && ln < VA[g] + VF[g] + VS[g]) ? POL[g] : !POL[g];
      o.act = a;
      o.x = a ? 10'(hp) : 10'd0;
      o.y = a ? 10'(ln) : 10'd0;
      o.rgb = (a && valid) ? d : 24'd0;
      o.fs = a && (hp == 0) && (ln == 0);
    end
    rdy_exp = a;
    if (a && !valid) o.uf = 1'b1;
    else if (clr) o.uf = 1'b0;
    return o;
  endfunction

  task automatic model_reset();
    for (int g = 0; g < 3; g++) begin
      mt[g] = 0;
      mo[g] = '0;
      mo[g].hs = !POL[g];
      mo[g].vs = !POL[g];
    end
  endtask

  task automatic step(input bit en, input bit valid, input bit clr);
    exp_t        e;
    bit          r [3];
    logic [23:0] d;
    @(negedge clk);
    cyc++;
    d = 24'(cyc * 66051 + 5);
    pix_en = en;
    clr_underflow = clr;
    if_s.pix_data = d; if_p.pix_data = d; if_d.pix_data = d;
    if_s.pix_valid = valid; if_p.pix_valid = valid; if_d.pix_valid = valid;
    for (int g = 0; g < 3; g++) begin
      mo[g] = predict(g, mo[g], mt[g], en, valid, clr, d, r[g]);
      if (en) mt[g]++;
      e[g] = mo[g];
    end
    sbq.push_back(e);
    mon_en = 1'b1;
    #1;
    for (int g = 0; g < 3; g++) chk("pix_ready", g, 32'(rdy[g]), 32'(r[g]));
  endtask

  task automatic chk_reset();
    for (int g = 0; g < 3; g++) begin
      chk("rst_hsync", g, 32'(hs[g]), (g == 1) ? 32'd0 : 32'd1);
      chk("rst_vsync", g, 32'(vs[g]), (g == 1) ? 32'd0 : 32'd1);
      chk("rst_active", g, 32'(act[g]), 32'd0);
      chk("rst_rgb", g, 32'(rgb[g]), 32'd0);
      chk("rst_x", g, 32'(xo[g]), 32'd0);
      chk("rst_y", g, 32'(yo[g]), 32'd0);
      chk("rst_frame_start", g, 32'(fs[g]), 32'd0);
      chk("rst_underflow", g, 32'(uf[g]), 32'd0);
    end
  endtask

  // Monitor: each edge after a stimulus push presents one expected output set.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (mon_en) begin
        #1;
        if (sbq.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL scoreboard @%0t: got empty queue expected an entry", $time);
        end else begin
          e = sbq.pop_front();
          for (int g = 0; g < 3; g++) begin
            chk("hsync", g, 32'(hs[g]), 32'(e[g].hs));
            chk("vsync", g, 32'(vs[g]), 32'(e[g].vs));
            chk("active", g, 32'(act[g]), 32'(e[g].act));
            chk("rgb", g, 32'(rgb[g]), 32'(e[g].rgb));
            chk("x", g, 32'(xo[g]), 32'(e[g].x));
            chk("y", g, 32'(yo[g]), 32'(e[g].y));
            chk("frame_start", g, 32'(fs[g]), 32'(e[g].fs));
            chk("underflow", g, 32'(uf[g]), 32'(e[g].uf));
          end
        end
      end
    end
  end

  initial begin
    if_s.pix_data = '0; if_p.pix_data = '0; if_d.pix_data = '0;
    if_s.pix_valid = 1'b0; if_p.pix_valid = 1'b0; if_d.pix_valid = 1'b0;
    model_reset();
    #2 reset_n = 1'b0;
    #11 chk_reset();
    @(negedge clk);
    #1 reset_n = 1'b1;

    // Continuous enables: underflow set, clear, set-beats-clear, ignored valid=0 in blank.
    for (int k = 0; k < 1200; k++) begin
      step(1'b1, !(k == 18 || k == 154 || k == 300), (k == 60 || k == 154 || k == 200));
    end

    // Enable every 4th clock; clear lands on a non-enable clock.
    for (int k = 0; k < 520; k++) begin
      step(k % 4 == 0, k != 68, k == 86);
    end

    // Land mid-frame on an active pixel with underflow set, then reset asynchronously.
    for (int k = 0; k < 22; k++) step(1'b1, k != 21, 1'b0);
    @(negedge clk);
    mon_en = 1'b0;
    pix_en = 1'b0;
    clr_underflow = 1'b0;
    #1 reset_n = 1'b0;
    #1 chk_reset();
    #1 reset_n = 1'b1;
    model_reset();

    for (int k = 0; k < 30; k++) step(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    mon_en = 1'b0;
    if (sbq.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
